serial_tx_arbiter: RTL and testbench
====================================

Name: serial_tx_arbiter

Overview:
- Shares the single UART transmitter (`tx_start`/`tx_busy`/`tx_data`) between NREQ byte-stream requesters.
  - Requester 0 is the command-response path of the serial command processor.
  - Other requesters are autonomous report sources, such as a periodic histogram/counter streamer.
- Arbitration is packet-atomic round-robin: once a requester is granted, all of its bytes up to `req_last` go out uninterrupted.
- The block sequences the start/busy handshake per byte and sits between the requesters and the UART TX instance.

Parameters:
- NREQ, 3, number of requesters (2..8).
- BUSY_WAIT, 4, maximum cycles to wait for `tx_busy` to rise after `tx_start` before assuming the byte was accepted.
- MAX_PKT, 64, maximum bytes per packet; the packet is force-terminated at this count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a byte on `req_data[i]`.
- req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i].
- req_last  in  NREQ  the byte presented by requester i is the final byte of its packet.
- req_ready  out  NREQ  byte accepted; one-cycle pulse, combinational from state.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle start pulse to the UART.
- tx_data  out  8  byte to the UART; held stable from `tx_start` until the next load.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- pkt_done  out  1  one-cycle pulse when a packet completes.
- overlen_err  out  1  one-cycle pulse when a packet hits MAX_PKT without `req_last`.

Behaviour:
- Reset values: all outputs 0; `last_grant` = NREQ-1, so requester 0 is first priority after reset; byte counter 0; state IDLE.
- States: IDLE, FETCH, START, WAIT_HI, WAIT_LO.
- IDLE:
  - If any `req_valid` is set, choose the first set bit searching upward (cyclically) from `last_grant`+1.
  - Register `grant` one-hot, clear the byte counter, then go to FETCH (one-cycle arbitration latency).
- FETCH:
  - If `req_valid[g]` and !`tx_busy`: `req_ready[g]`=1 this cycle, capture `req_data[g]` into `tx_data`, capture `req_last[g]`, increment the byte counter, then go to START.
  - Otherwise stay. The grant is held even if the owner drops `req_valid` mid-packet; there is no preemption.
- START: `tx_start`=1 for exactly one cycle, then go to WAIT_HI with the wait counter cleared.
- WAIT_HI: go to WAIT_LO when `tx_busy`=1 or when the wait counter reaches BUSY_WAIT-1. The counter increments every cycle.
- WAIT_LO: when `tx_busy`=0:
  - If the captured last flag is set: pulse `pkt_done`, set `last_grant`=g, clear `grant`, go to IDLE.
  - Else if the byte counter equals MAX_PKT: pulse `pkt_done` and `overlen_err`, do the same release, go to IDLE.
  - Else go to FETCH.
- Latency from the first `req_valid` (bus idle) to `tx_start` is 3 cycles (IDLE→FETCH→START). The minimum per-byte overhead beyond UART busy time is 3 cycles.
- `req_ready` is never asserted for a non-granted requester and never more than once per byte.
- Byte counter: 8 bits, saturating at MAX_PKT; it never wraps.
- Simultaneous requests while idle: the round-robin order is the only tiebreak. Requests arriving during a packet wait until the release.
- `req_last` on the first byte gives a 1-byte packet. MAX_PKT=1 forces every packet to one byte; `overlen_err` fires only if `req_last`=0.
- `tx_busy` already high in FETCH: wait. `tx_busy` never rising: the WAIT_HI timeout covers it.
- Reset asserted mid-packet:
  - Immediate return to IDLE, all outputs 0, and any partially sent packet is abandoned.
  - Requesters must restart their packets after reset.
  - `last_grant` returns to NREQ-1.

Decomposition:
- The shared package `dist_board_pkg` holds the state enum, the BUSY_WAIT/MAX_PKT defaults and a `byte_t` typedef.
- Sub-module `rr_arbiter` (NREQ parameter): request vector plus `last_grant` in, combinational one-hot grant out. Reusable for other shared resources.

Test Plan:
- Single request: with NREQ=3, req0 sends the 1-byte packet 0x07 with `req_last`=1 and the UART model holds busy 10 cycles → `tx_start` 3 cycles after valid, `tx_data`=0x07, `pkt_done` after busy falls, `grant` returns to 0.
- Contention: req0 (bytes 0xA1,0xA2,last) and req2 (bytes 0xB1,last) assert together after reset → UART sees A1,A2,B1 in that order; a second simultaneous round sees B-stream first (round-robin from `last_grant`=0 picks 1, then 2).
- Atomicity: req1 drops valid for 20 cycles mid-packet while req0 is valid → no `req_ready`[0], `grant` stays on req1, and its packet completes before req0 is served.
- Busy timeout: UART model never raises busy → WAIT_HI exits after 4 cycles, the next byte follows, and no hang.
- Overlength: MAX_PKT=4, req2 streams 6 bytes with no `req_last` → exactly 4 `req_ready` pulses, then `pkt_done`+`overlen_err` together; the remaining bytes start a new packet after rearbitration.
- Reset mid-packet: `rst_n` low during WAIT_HI of byte 2 → `tx_start`, `grant` and `req_ready` drop to 0 immediately; after release, req0 wins first.

Source files
------------

// File: rtl/dist_board_pkg.sv
// Shared types and defaults for the serial transmit arbitration logic.
package dist_board_pkg;

    typedef logic [7:0] byte_t;

    // Byte sequencing states of the transmit arbiter.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } tx_state_t;

    localparam int DEF_BUSY_WAIT = 4;
    localparam int DEF_MAX_PKT   = 64;
    localparam int BYTE_CNT_W    = 8;

    // Width of an index able to address n requesters (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester found searching
// cyclically upward from the one after last_grant_i.
module rr_arbiter
    import dist_board_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            any_o
);

    // Walk the requesters in priority order starting just after the last owner.
    always_comb begin
        logic found;
        int   idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = |req_i;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte-stream requesters with
// packet-atomic round-robin arbitration and a per-byte start/busy handshake.
module serial_tx_arbiter
    import dist_board_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int BUSY_WAIT = DEF_BUSY_WAIT,
    parameter int MAX_PKT   = DEF_MAX_PKT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [NREQ-1:0]   grant,
    output logic              pkt_done,
    output logic              overlen_err
);

    localparam int IW = idx_w(NREQ);
    localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_PKT);

    tx_state_t             state_q, state_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  last_flag_q, last_flag_d;
    byte_t                 tx_data_q, tx_data_d;

    logic [NREQ-1:0]       arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  release_pkt;

    byte_t                 req_bytes [NREQ];

    // Split the flat data bus into one byte lane per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lanes
        assign req_bytes[gi] = req_data[8*gi +: 8];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (arb_gnt),
        .gnt_idx_o    (arb_idx),
        .any_o        (arb_any)
    );

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= IW'(NREQ - 1);
            byte_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            last_flag_q  <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            last_flag_q  <= last_flag_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // Next-state logic plus the pulse outputs that depend on the current state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        last_flag_d  = last_flag_q;
        tx_data_d    = tx_data_q;
        req_ready    = '0;
        pkt_done     = 1'b0;
        overlen_err  = 1'b0;
        release_pkt  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_gnt;
                    gidx_d     = arb_idx;
                    byte_cnt_d = '0;
                    state_d    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // The owner keeps the grant even while its valid is low.
                if (req_valid[gidx_q] && !tx_busy) begin
                    req_ready   = grant_q;
                    tx_data_d   = req_bytes[gidx_q];
                    last_flag_d = req_last[gidx_q];
                    if (byte_cnt_q < MAX_CNT) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                    state_d = ST_START;
                end
            end

            ST_START: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT_HI;
            end

            ST_WAIT_HI: begin
                // A UART that never raises busy is assumed to have taken the byte.
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (tx_busy || (wait_cnt_q == WW'(BUSY_WAIT - 1))) begin
                    state_d = ST_WAIT_LO;
                end
            end

            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_flag_q) begin
                        release_pkt = 1'b1;
                    end else if (byte_cnt_q == MAX_CNT) begin
                        release_pkt = 1'b1;
                        overlen_err = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (release_pkt) begin
            pkt_done     = 1'b1;
            last_grant_d = gidx_q;
            grant_d      = '0;
            state_d      = ST_IDLE;
        end
    end

    assign tx_start = (state_q == ST_START);
    assign tx_data  = tx_data_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed self-checking bench for serial_tx_arbiter with a UART busy model
// and queue-driven requesters.
module tb_serial_tx_arbiter;

    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [NREQ-1:0]   grant;
    logic              pkt_done;
    logic              overlen_err;

    serial_tx_arbiter #(
        .NREQ      (NREQ),
        .BUSY_WAIT (4),
        .MAX_PKT   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant       (grant),
        .pkt_done    (pkt_done),
        .overlen_err (overlen_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [NREQ-1:0] hold = '0;

    logic [7:0] tx_log[$];
    int         start_cyc[$];
    int         rdy_cnt[NREQ];
    int         done_cnt = 0;
    int         ovl_cnt  = 0;
    int         both_cnt = 0;
    int         cyc      = 0;
    int         busy_len = 10;
    int         busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        case (r)
            0: q0.push_back({l, d});
            1: q1.push_back({l, d});
            default: q2.push_back({l, d});
        endcase
    endtask

    task automatic clear_stats();
        tx_log.delete();
        start_cyc.delete();
        for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
        done_cnt = 0;
        ovl_cnt  = 0;
        both_cnt = 0;
    endtask

    task automatic drive_reqs();
        req_valid[0]  = (q0.size() > 0) && !hold[0];
        req_data[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req_last[0]   = (q0.size() > 0) ? q0[0][8] : 1'b0;
        req_valid[1]   = (q1.size() > 0) && !hold[1];
        req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
        req_valid[2]    = (q2.size() > 0) && !hold[2];
        req_data[23:16] = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
        req_last[2]     = (q2.size() > 0) ? q2[0][8] : 1'b0;
    endtask

    // Monitor at the falling edge, then update requesters and UART after the rising edge.
    initial begin
        logic [NREQ-1:0] rdy;
        logic            st;
        forever begin
            @(negedge clk);
            cyc++;
            rdy = req_ready;
            st  = tx_start;
            if (st) begin
                tx_log.push_back(tx_data);
                start_cyc.push_back(cyc);
                $display("[%0t] tx byte 0x%02h grant=%b", $time, tx_data, grant);
            end
            for (int i = 0; i < NREQ; i++) rdy_cnt[i] += int'(rdy[i]);
            if (pkt_done) done_cnt++;
            if (overlen_err) ovl_cnt++;
            if (pkt_done && overlen_err) both_cnt++;
            if (rdy != '0) begin
                check("ready_only_granted", 32'(rdy & ~grant), 32'd0);
                check("ready_onehot", 32'($countones(rdy)), 32'd1);
            end
            @(posedge clk);
            #1;
            if (rdy[0] && q0.size() > 0) void'(q0.pop_front());
            if (rdy[1] && q1.size() > 0) void'(q1.pop_front());
            if (rdy[2] && q2.size() > 0) void'(q2.pop_front());
            if (!rst_n) begin
                tx_busy  = 1'b0;
                busy_cnt = 0;
            end else if (st && busy_len > 0) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            drive_reqs();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_overlen", 32'(overlen_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single 1-byte packet from requester 0
        busy_len = 10;
        push(0, 8'h07, 1'b1);
        tick();
        check("single_idle_grant", 32'(grant), 32'd0);
        tick();
        check("single_fetch_grant", 32'(grant), 32'b001);
        check("single_fetch_ready", 32'(req_ready), 32'b001);
        check("single_fetch_start", 32'(tx_start), 32'd0);
        tick();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_tx_data", 32'(tx_data), 32'h07);
        tick();
        check("single_start_pulse", 32'(tx_start), 32'd0);
        check("single_hold_grant", 32'(grant), 32'b001);
        for (int k = 0; k < 40; k++) begin
            if (done_cnt >= 1) break;
            tick();
        end
        check("single_done", 32'(done_cnt), 32'd1);
        tick();
        check("single_release", 32'(grant), 32'd0);
        check("single_done_once", 32'(done_cnt), 32'd1);
        check("single_no_ovl", 32'(ovl_cnt), 32'd0);
        check("single_tx_data_held", 32'(tx_data), 32'h07);

        // Reset pulse, then contention between requesters 0 and 2
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        busy_len = 3;
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b1);
        push(2, 8'hB1, 1'b1);
        for (int k = 0; k < 100; k++) begin
            if (done_cnt >= 2) break;
            tick();
        end
        check("cont_done", 32'(done_cnt), 32'd2);
        check("cont_count", 32'(tx_log.size()), 32'd3);
        if (tx_log.size() >= 3) begin
            check("cont_byte0", 32'(tx_log[0]), 32'hA1);
            check("cont_byte1", 32'(tx_log[1]), 32'hA2);
            check("cont_byte2", 32'(tx_log[2]), 32'hB1);
        end
        push(0, 8'hA3, 1'b1);
        for (int k = 0; k < 60; k++) begin
            if (done_cnt >= 3) break;
            tick();
        end
        push(0, 8'hA4, 1'b1);
        push(2, 8'hB2, 1'b1);
        for (int k = 0; k < 100; k++) begin
            if (done_cnt >= 5) break;
            tick();
        end
        check("rr_done", 32'(done_cnt), 32'd5);
        check("rr_count", 32'(tx_log.size()), 32'd6);
        if (tx_log.size() >= 6) begin
            check("rr_solo", 32'(tx_log[3]), 32'hA3);
            check("rr_first", 32'(tx_log[4]), 32'hB2);
            check("rr_second", 32'(tx_log[5]), 32'hA4);
        end
        tick();

        // Atomicity: requester 1 stalls mid-packet while requester 0 waits
        clear_stats();
        push(1, 8'hC1, 1'b0);
        push(1, 8'hC2, 1'b1);
        for (int k = 0; k < 30; k++) begin
            if (rdy_cnt[1] >= 1) break;
            tick();
        end
        hold[1] = 1'b1;
        push(0, 8'hD1, 1'b1);
        repeat (20) tick();
        check("atom_no_ready0", 32'(rdy_cnt[0]), 32'd0);
        check("atom_grant", 32'(grant), 32'b010);
        check("atom_ready1", 32'(rdy_cnt[1]), 32'd1);
        hold[1] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done_cnt >= 2) break;
            tick();
        end
        check("atom_done", 32'(done_cnt), 32'd2);
        check("atom_count", 32'(tx_log.size()), 32'd3);
        if (tx_log.size() >= 3) begin
            check("atom_byte0", 32'(tx_log[0]), 32'hC1);
            check("atom_byte1", 32'(tx_log[1]), 32'hC2);
            check("atom_byte2", 32'(tx_log[2]), 32'hD1);
        end
        tick();

        // Reset during WAIT_HI of the second byte of requester 1's packet
        clear_stats();
        push(1, 8'hE1, 1'b0);
        push(1, 8'hE2, 1'b0);
        push(1, 8'hE3, 1'b1);
        for (int k = 0; k < 60; k++) begin
            if (tx_log.size() >= 2) break;
            tick();
        end
        check("rst_mid_started", 32'(tx_log.size()), 32'd2);
        tick();
        check("rst_mid_pre_grant", 32'(grant), 32'b010);
        rst_n = 1'b0;
        #1;
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_start", 32'(tx_start), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        push(1, 8'hF1, 1'b1);
        push(0, 8'h61, 1'b1);
        for (int k = 0; k < 100; k++) begin
            if (done_cnt >= 2) break;
            tick();
        end
        check("rst_after_done", 32'(done_cnt), 32'd2);
        check("rst_after_count", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() >= 2) begin
            check("rst_after_first", 32'(tx_log[0]), 32'h61);
            check("rst_after_second", 32'(tx_log[1]), 32'hF1);
        end
        tick();

        // Busy never rises: WAIT_HI times out and the next byte follows
        clear_stats();
        busy_len = 0;
        push(2, 8'h71, 1'b0);
        push(2, 8'h72, 1'b1);
        for (int k = 0; k < 60; k++) begin
            if (done_cnt >= 1) break;
            tick();
        end
        check("tmo_done", 32'(done_cnt), 32'd1);
        check("tmo_count", 32'(start_cyc.size()), 32'd2);
        if (start_cyc.size() >= 2) begin
            check("tmo_spacing", 32'(start_cyc[1] - start_cyc[0]), 32'd7);
            check("tmo_byte1", 32'(tx_log[1]), 32'h72);
        end
        tick();

        // Overlength: 6 bytes with no last flag and MAX_PKT=4
        clear_stats();
        busy_len = 2;
        for (int b = 0; b < 6; b++) push(2, 8'(8'h30 + b), 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (done_cnt >= 1) break;
            tick();
        end
        check("ovl_done", 32'(done_cnt), 32'd1);
        check("ovl_ready_cnt", 32'(rdy_cnt[2]), 32'd4);
        check("ovl_err", 32'(ovl_cnt), 32'd1);
        check("ovl_together", 32'(both_cnt), 32'd1);
        for (int k = 0; k < 60; k++) begin
            if (rdy_cnt[2] >= 6) break;
            tick();
        end
        repeat (10) tick();
        check("ovl_second_ready", 32'(rdy_cnt[2]), 32'd6);
        check("ovl_regrant", 32'(grant), 32'b100);
        check("ovl_no_extra_done", 32'(done_cnt), 32'd1);
        push(2, 8'h36, 1'b1);
        for (int k = 0; k < 60; k++) begin
            if (done_cnt >= 2) break;
            tick();
        end
        check("ovl_final_done", 32'(done_cnt), 32'd2);
        check("ovl_final_err", 32'(ovl_cnt), 32'd1);
        check("ovl_count", 32'(tx_log.size()), 32'd7);
        if (tx_log.size() >= 7) begin
            check("ovl_byte3", 32'(tx_log[3]), 32'h33);
            check("ovl_byte4", 32'(tx_log[4]), 32'h34);
            check("ovl_byte6", 32'(tx_log[6]), 32'h36);
        end
        tick();
        check("end_idle", 32'(grant), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
